// File: rtl/tmr_mismatch_monitor.sv
// rtl/tmr_mismatch_monitor.sv - per-lane mismatch counters and fault flags beside a TMR voter
// Optional first-fault capture (first_syn/first_lane) is built when TMR_MON_CAPTURE_EN is defined.
module tmr_mismatch_monitor #(
  parameter int REG_WIDTH   = 1,
  parameter int CNT_WIDTH   = 16,
  parameter int PERSIST_CYC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [REG_WIDTH-1:0] st_r1,
  input  logic [REG_WIDTH-1:0] st_r2,
  input  logic [REG_WIDTH-1:0] st_r3,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] lane_err_cnt0,
  output logic [CNT_WIDTH-1:0] lane_err_cnt1,
  output logic [CNT_WIDTH-1:0] lane_err_cnt2,
  output logic [2:0]           lane_fail,
  output logic                 multi_err,
  output logic                 err_irq
`ifdef TMR_MON_CAPTURE_EN
  ,
  output logic [REG_WIDTH-1:0] first_syn,
  output logic [2:0]           first_lane
`endif
);

  localparam int RUN_W = $clog2(PERSIST_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST_CYC);

  logic [REG_WIDTH-1:0] s1_r_q [3];
  logic                 s1_valid_q;
  logic [REG_WIDTH-1:0] voted;
  logic [2:0]           mis;
  logic [2:0]           s2_mis_q;
  logic                 s2_valid_q;

  logic [CNT_WIDTH-1:0] cnt_q [3];
  logic [CNT_WIDTH-1:0] cnt_d [3];
  logic [RUN_W-1:0]     run_q [3];
  logic [RUN_W-1:0]     run_d [3];
  logic [2:0]           lane_fail_q, lane_fail_d;
  logic                 multi_q, multi_d;
  logic                 irq_q, irq_d;

  always_comb begin
    voted = (s1_r_q[0] & s1_r_q[1]) | (s1_r_q[0] & s1_r_q[2]) | (s1_r_q[1] & s1_r_q[2]);
    mis   = '0;
    for (int k = 0; k < 3; k++) begin
      mis[k] = |(s1_r_q[k] ^ voted);
    end
  end

  // Clear has priority over the sample in S3, which is then dropped.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      run_d[k] = run_q[k];
    end
    lane_fail_d = lane_fail_q;
    multi_d     = multi_q;
    irq_d       = 1'b0;
    if (err_clr) begin
      for (int k = 0; k < 3; k++) begin
        cnt_d[k] = '0;
        run_d[k] = '0;
      end
      lane_fail_d = '0;
      multi_d     = 1'b0;
    end else if (s2_valid_q) begin
      for (int k = 0; k < 3; k++) begin
        if (s2_mis_q[k]) begin
          if (cnt_q[k] != {CNT_WIDTH{1'b1}}) cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
          if (run_q[k] != RUN_MAX) run_d[k] = run_q[k] + RUN_W'(1);
          if (run_d[k] == RUN_MAX) lane_fail_d[k] = 1'b1;
        end else begin
          run_d[k] = '0;
        end
      end
      if ((s2_mis_q[0] & s2_mis_q[1]) | (s2_mis_q[0] & s2_mis_q[2]) | (s2_mis_q[1] & s2_mis_q[2]))
        multi_d = 1'b1;
      irq_d = (|(lane_fail_d & ~lane_fail_q)) | (multi_d & ~multi_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        s1_r_q[k] <= '0;
        cnt_q[k]  <= '0;
        run_q[k]  <= '0;
      end
      s1_valid_q  <= 1'b0;
      s2_mis_q    <= '0;
      s2_valid_q  <= 1'b0;
      lane_fail_q <= '0;
      multi_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      s1_r_q[0]   <= st_r1;
      s1_r_q[1]   <= st_r2;
      s1_r_q[2]   <= st_r3;
      s1_valid_q  <= in_valid;
      s2_mis_q    <= mis;
      s2_valid_q  <= s1_valid_q;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
        run_q[k] <= run_d[k];
      end
      lane_fail_q <= lane_fail_d;
      multi_q     <= multi_d;
      irq_q       <= irq_d;
    end
  end

  assign lane_err_cnt0 = cnt_q[0];
  assign lane_err_cnt1 = cnt_q[1];
  assign lane_err_cnt2 = cnt_q[2];
  assign lane_fail     = lane_fail_q;
  assign multi_err     = multi_q;
  assign err_irq       = irq_q;

`ifdef TMR_MON_CAPTURE_EN
  logic [REG_WIDTH-1:0] syn;
  logic [REG_WIDTH-1:0] s2_syn_q;
  logic [REG_WIDTH-1:0] first_syn_q, first_syn_d;
  logic [2:0]           first_lane_q, first_lane_d;

  assign syn = (s1_r_q[0] ^ voted) | (s1_r_q[1] ^ voted) | (s1_r_q[2] ^ voted);

  // A non-zero first_lane marks the capture as taken; a mismatching sample always has one.
  always_comb begin
    first_syn_d  = first_syn_q;
    first_lane_d = first_lane_q;
    if (err_clr) begin
      first_syn_d  = '0;
      first_lane_d = '0;
    end else if (s2_valid_q && (|s2_mis_q) && (first_lane_q == 3'b000)) begin
      first_syn_d  = s2_syn_q;
      first_lane_d = s2_mis_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_syn_q     <= '0;
      first_syn_q  <= '0;
      first_lane_q <= '0;
    end else begin
      s2_syn_q     <= syn;
      first_syn_q  <= first_syn_d;
      first_lane_q <= first_lane_d;
    end
  end

  assign first_syn  = first_syn_q;
  assign first_lane = first_lane_q;
`endif

endmodule

// File: tb/tb_tmr_mismatch_monitor.sv
// tb/tb_tmr_mismatch_monitor.sv - self-checking bench for tmr_mismatch_monitor
// Compile with TMR_MON_CAPTURE_EN defined to also check the first-fault capture ports.
module tb_tmr_mismatch_monitor;
  localparam int RW = 4;
  localparam int CW = 2;
  localparam int PC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic [RW-1:0] st_r1 = '0, st_r2 = '0, st_r3 = '0;
  logic [CW-1:0] lane_err_cnt0, lane_err_cnt1, lane_err_cnt2;
  logic [2:0]    lane_fail;
  logic          multi_err, err_irq;
`ifdef TMR_MON_CAPTURE_EN
  logic [RW-1:0] first_syn;
  logic [2:0]    first_lane;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic [RW-1:0] c;
  } samp_t;

  samp_t         hist[$];
  int            m_cnt[3];
  int            m_run[3];
  logic [2:0]    m_fail;
  logic          m_multi, m_irq;
  logic [RW-1:0] m_syn;
  logic [2:0]    m_lane;

  always #5 clk = ~clk;

  tmr_mismatch_monitor #(.REG_WIDTH(RW), .CNT_WIDTH(CW), .PERSIST_CYC(PC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .st_r1(st_r1), .st_r2(st_r2), .st_r3(st_r3), .err_clr(err_clr),
    .lane_err_cnt0(lane_err_cnt0), .lane_err_cnt1(lane_err_cnt1), .lane_err_cnt2(lane_err_cnt2),
    .lane_fail(lane_fail), .multi_err(multi_err), .err_irq(err_irq)
`ifdef TMR_MON_CAPTURE_EN
    , .first_syn(first_syn), .first_lane(first_lane)
`endif
  );

  task automatic model_zero();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_run[k] = 0;
    end
    m_fail = '0; m_multi = 1'b0; m_irq = 1'b0; m_syn = '0; m_lane = '0;
  endtask

  // Reference: each sample affects the outputs three edges after it is driven.
  task automatic model_edge();
    samp_t         s;
    logic [RW-1:0] r[3];
    logic [RW-1:0] vt;
    logic [2:0]    mis;
    logic          rise;
    if (!rst_n) begin
      hist.delete();
      model_zero();
      return;
    end
    hist.push_back({in_valid, st_r1, st_r2, st_r3});
    m_irq = 1'b0;
    s = '0;
    if (hist.size() == 3) s = hist.pop_front();
    if (err_clr) begin
      model_zero();
      return;
    end
    if (!s.v) return;
    r[0] = s.a; r[1] = s.b; r[2] = s.c;
    for (int i = 0; i < RW; i++)
      vt[i] = (int'(r[0][i]) + int'(r[1][i]) + int'(r[2][i])) >= 2;
    rise = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mis[k] = (r[k] != vt);
      if (mis[k]) begin
        if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
        if (m_run[k] < PC) m_run[k]++;
        if (m_run[k] == PC && !m_fail[k]) begin
          m_fail[k] = 1'b1;
          rise = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    if ((int'(mis[0]) + int'(mis[1]) + int'(mis[2])) >= 2 && !m_multi) begin
      m_multi = 1'b1;
      rise = 1'b1;
    end
    if (mis != 3'b000 && m_lane == 3'b000) begin
      m_syn  = (r[0] ^ vt) | (r[1] ^ vt) | (r[2] ^ vt);
      m_lane = mis;
    end
    m_irq = rise;
  endtask

  task automatic tick(input logic v, input logic [RW-1:0] a, input logic [RW-1:0] b,
                      input logic [RW-1:0] c, input logic clr);
    in_valid = v; st_r1 = a; st_r2 = b; st_r3 = c; err_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_flush();
    tick(1'b0, '0, '0, '0, 1'b1);
    repeat (3) tick(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if ({lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0",
               {lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq});
    end
`ifdef TMR_MON_CAPTURE_EN
    n_checks++;
    if ({first_syn, first_lane} !== '0) begin
      n_fail++;
      $display("FAIL reset_capture got %h required 0", {first_syn, first_lane});
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_all_equal();
    clear_flush();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 4'hA, 4'hA, 4'hA, 1'b0);
      n_checks++;
      if (err_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL equal_irq cycle %0d got %b required 0", i, err_irq);
      end
    end
    repeat (3) tick(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if ({lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq} !== '0) begin
      n_fail++;
      $display("FAIL equal_final got %h required 0",
               {lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq});
    end
  endtask

  task automatic test_single_lane();
    clear_flush();
    tick(1'b1, 4'hA, 4'hB, 4'hA, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) tick(1'b0, '0, '0, '0, 1'b0);
      n_checks++;
      if ({lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, err_irq} !==
          {CW'(0), CW'(i == 3 ? 1 : 0), CW'(0), 1'b0}) begin
        n_fail++;
        $display("FAIL single_latency edge %0d got cnt %0d/%0d/%0d irq %b required cnt1=%0d others 0 irq 0",
                 i, lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, err_irq, (i == 3) ? 1 : 0);
      end
    end
`ifdef TMR_MON_CAPTURE_EN
    n_checks++;
    if ({first_syn, first_lane} !== {4'h1, 3'b010}) begin
      n_fail++;
      $display("FAIL single_capture got syn %h lane %b required syn 1 lane 010", first_syn, first_lane);
    end
`endif
  endtask

  task automatic test_persist();
    int pulses;
    clear_flush();
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) tick(1'b1, 4'h5, 4'hA, 4'hA, 1'b0);
      else tick(1'b0, '0, '0, '0, 1'b0);
      pulses += int'(err_irq);
      n_checks++;
      if ({lane_fail, err_irq} !== {m_fail, m_irq}) begin
        n_fail++;
        $display("FAIL persist_step %0d got fail %b irq %b required fail %b irq %b",
                 i, lane_fail, err_irq, m_fail, m_irq);
      end
    end
    n_checks++;
    if (lane_fail !== 3'b001 || pulses != 1) begin
      n_fail++;
      $display("FAIL persist_final got fail %b pulses %0d required 001 and 1", lane_fail, pulses);
    end
    clear_flush();
    for (int i = 0; i < 15; i++)
      tick(1'b1, (i == 7) ? 4'hA : 4'h5, 4'hA, 4'hA, 1'b0);
    repeat (3) tick(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if (lane_fail !== 3'b000) begin
      n_fail++;
      $display("FAIL persist_broken_run got fail %b required 000", lane_fail);
    end
  endtask

  task automatic test_multi();
    int pulses;
    clear_flush();
    pulses = 0;
    tick(1'b1, 4'h8, 4'h1, 4'h0, 1'b0);
    repeat (4) begin
      tick(1'b0, '0, '0, '0, 1'b0);
      pulses += int'(err_irq);
    end
    n_checks++;
    if ({multi_err, lane_err_cnt0, lane_err_cnt1, lane_err_cnt2} !== {1'b1, CW'(1), CW'(1), CW'(0)}
        || pulses != 1) begin
      n_fail++;
      $display("FAIL multi got multi %b cnt %0d/%0d/%0d pulses %0d required 1 cnt 1/1/0 pulses 1",
               multi_err, lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, pulses);
    end
  endtask

  task automatic test_saturate_clear();
    clear_flush();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 4'hA, 4'hA, 4'h5, 1'b0);
      tick(1'b1, 4'hA, 4'hA, 4'hA, 1'b0);
    end
    repeat (3) tick(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if ({lane_err_cnt0, lane_err_cnt1, lane_err_cnt2} !== {CW'(0), CW'(0), CW'(3)}) begin
      n_fail++;
      $display("FAIL saturate got cnt2 %0d required 3", lane_err_cnt2);
    end
    tick(1'b1, 4'hA, 4'hA, 4'h5, 1'b0);
    tick(1'b1, 4'hA, 4'hA, 4'h5, 1'b0);
    tick(1'b0, '0, '0, '0, 1'b1);
    n_checks++;
    if ({lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq} !== '0) begin
      n_fail++;
      $display("FAIL clear_wins got %h required 0",
               {lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq});
    end
    tick(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if (lane_err_cnt2 !== CW'(1)) begin
      n_fail++;
      $display("FAIL clear_inflight got cnt2 %0d required 1", lane_err_cnt2);
    end
  endtask

  task automatic test_reset_midrun();
    clear_flush();
    tick(1'b1, 4'h8, 4'h1, 4'h0, 1'b0);
    repeat (3) tick(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if (multi_err !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_setup got multi %b required 1", multi_err);
    end
    tick(1'b1, 4'hA, 4'hB, 4'hA, 1'b0);
    rst_n = 1'b0;
    tick(1'b1, 4'hA, 4'hB, 4'hA, 1'b0);
    n_checks++;
    if ({lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset got %h required 0",
               {lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq});
    end
`ifdef TMR_MON_CAPTURE_EN
    n_checks++;
    if ({first_syn, first_lane} !== '0) begin
      n_fail++;
      $display("FAIL midrun_capture got %h required 0", {first_syn, first_lane});
    end
`endif
    rst_n = 1'b1;
    repeat (3) tick(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if ({lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, multi_err} !== '0) begin
      n_fail++;
      $display("FAIL midrun_dropped got cnt %0d/%0d/%0d multi %b required 0",
               lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, multi_err);
    end
  endtask

  task automatic test_random();
    clear_flush();
    for (int i = 0; i < 400; i++) begin
      logic [RW-1:0] base, a, b, c;
      logic          v, clr;
      base = RW'($urandom);
      a = base; b = base; c = base;
      if ($urandom_range(0, 5) == 0) a = RW'($urandom);
      if ($urandom_range(0, 9) == 0) b = RW'($urandom);
      if (i >= 150 && i < 200) c = ~base;
      else if ($urandom_range(0, 7) == 0) c = RW'($urandom);
      v   = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 60) == 0);
      tick(v, a, b, c, clr);
      n_checks++;
      if ({lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq} !==
          {CW'(m_cnt[0]), CW'(m_cnt[1]), CW'(m_cnt[2]), m_fail, m_multi, m_irq}) begin
        n_fail++;
        $display("FAIL random cycle %0d got %h required %h", i,
                 {lane_err_cnt0, lane_err_cnt1, lane_err_cnt2, lane_fail, multi_err, err_irq},
                 {CW'(m_cnt[0]), CW'(m_cnt[1]), CW'(m_cnt[2]), m_fail, m_multi, m_irq});
      end
`ifdef TMR_MON_CAPTURE_EN
      n_checks++;
      if ({first_syn, first_lane} !== {m_syn, m_lane}) begin
        n_fail++;
        $display("FAIL random_capture cycle %0d got %h required %h", i,
                 {first_syn, first_lane}, {m_syn, m_lane});
      end
`endif
    end
  endtask

  initial begin
    model_zero();
    test_reset();
    test_all_equal();
    test_single_lane();
    test_persist();
    test_multi();
    test_saturate_clear();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
